mem_arbiter: RTL

- Responder end of the cache-to-memory channel and driver end of the snoop bus.
- Accepts byte requests from NUM_CORES private caches and grants one request at a time, round-robin.
- Broadcasts each accepted request on the snoop bus, then performs the access on an internal main-memory byte array after a fixed latency and returns the response to the winning cache.

---
 rtl/system_widths_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/system_widths_pkg.sv
// Shared widths and types for the cache-to-memory channel and the snoop bus.
package system_widths_pkg;

    localparam int ADDR_W        = 11;
    localparam int NUM_CORES_MAX = 4;
    localparam int MEM_BYTES     = 1 << ADDR_W;

    typedef enum logic {
        SNOOP_RD  = 1'b0,
        SNOOP_RFO = 1'b1
    } snoop_cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SNOOP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
    import system_widths_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    int w_pos;

    // Rotating priority search; the pointer is always below N so one wrap suffices.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end else begin
                w_pos = w_pos;
            end
            if (!o_any && i_req[SEL_W'(w_pos)]) begin
                o_grant[SEL_W'(w_pos)] = 1'b1;
                o_idx                  = IDX_W'(w_pos);
                o_any                  = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin memory arbiter: grant, snoop broadcast, fixed-latency byte access, response.
module mem_arbiter
    import system_widths_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int MEM_LAT   = 3,
    parameter int ADDR_W    = system_widths_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        mem_req_valid,
    input  logic [NUM_CORES-1:0]        mem_req_we,
    input  logic [NUM_CORES*ADDR_W-1:0] mem_req_addr,
    input  logic [NUM_CORES*8-1:0]      mem_req_write,
    output logic [NUM_CORES-1:0]        mem_req_ready,
    output logic [NUM_CORES-1:0]        mem_resp_valid,
    output logic [7:0]                  mem_resp_data,
    output logic                        snoop_valid,
    output logic [1:0]                  snoop_core,
    output logic                        snoop_cmd,
    output logic [ADDR_W-1:0]           snoop_addr
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [1:0]            r_ptr;
    logic [1:0]            r_win;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_wdata;
    logic [CNT_W-1:0]      r_cnt;
    logic [7:0]            r_mem [DEPTH];

    logic [NUM_CORES-1:0]  r_resp_valid;
    logic [7:0]            r_resp_data;
    logic                  r_snoop_valid;
    logic [1:0]            r_snoop_core;
    snoop_cmd_e            r_snoop_cmd;
    logic [ADDR_W-1:0]     r_snoop_addr;

    logic [NUM_CORES-1:0]  w_grant;
    logic [1:0]            w_idx;
    logic                  w_any;
    logic                  w_accept;
    logic                  w_commit;
    logic [1:0]            w_ptr_nxt;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [7:0]            w_sel_wdata;

    rr_arbiter #(
        .N     (NUM_CORES),
        .IDX_W (2)
    ) u_rr (
        .i_req   (mem_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // The access commits only on the final ACCESS edge, so a reset before then leaves memory untouched.
    assign w_accept    = (r_state == IDLE) && w_any;
    assign w_commit    = (r_state == ACCESS) && (r_cnt == '0);
    assign w_ptr_nxt   = (w_idx == 2'(NUM_CORES - 1)) ? 2'd0 : (w_idx + 2'd1);
    assign w_sel_we    = mem_req_we[w_idx];
    assign w_sel_addr  = mem_req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = mem_req_write[w_idx*8 +: 8];

    assign mem_req_ready  = w_accept ? w_grant : '0;
    assign mem_resp_valid = r_resp_valid;
    assign mem_resp_data  = r_resp_data;
    assign snoop_valid    = r_snoop_valid;
    assign snoop_core     = r_snoop_core;
    assign snoop_cmd      = r_snoop_cmd;
    assign snoop_addr     = r_snoop_addr;

    // Next-state logic for the transaction sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SNOOP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SNOOP:  w_state_nxt = ACCESS;
            ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ACCESS;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched request, latency counter and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= 2'd0;
            r_win         <= 2'd0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 8'd0;
            r_cnt         <= '0;
            r_resp_valid  <= '0;
            r_resp_data   <= 8'd0;
            r_snoop_valid <= 1'b0;
            r_snoop_core  <= 2'd0;
            r_snoop_cmd   <= SNOOP_RD;
            r_snoop_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_win   <= w_idx;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_ptr   <= w_ptr_nxt;
            end
            r_snoop_valid <= w_accept;
            r_snoop_core  <= w_accept ? w_idx : 2'd0;
            r_snoop_cmd   <= (w_accept && w_sel_we) ? SNOOP_RFO : SNOOP_RD;
            r_snoop_addr  <= w_accept ? w_sel_addr : '0;
            if (r_state == SNOOP) begin
                r_cnt <= CNT_W'(MEM_LAT - 1);
            end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            r_resp_valid <= w_commit ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << r_win) : '0;
            if (w_commit) begin
                r_resp_data <= r_we ? r_wdata : r_mem[r_addr];
            end
        end
    end

    // Main-memory byte array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit && r_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
